// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode map, ALU/select encodings, control bundle and FSM states for the decode stage
package ctrl_pkg;
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHR   = 5'b11010;
    localparam logic [4:0] OP_ALUR  = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    localparam logic [2:0] ALU_ROL  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_ROR  = 3'b010;
    localparam logic [2:0] ALU_SRL  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_ANDN = 3'b111;

    localparam logic [1:0] WSEL_75  = 2'b00;
    localparam logic [1:0] WSEL_42  = 2'b01;
    localparam logic [1:0] WSEL_108 = 2'b10;
    localparam logic [1:0] WSEL_R7  = 2'b11;

    localparam logic [1:0] LEN_5  = 2'b00;
    localparam logic [1:0] LEN_8  = 2'b01;
    localparam logic [1:0] LEN_11 = 2'b10;

    localparam logic [1:0] BR_EQZ = 2'b00;
    localparam logic [1:0] BR_NEZ = 2'b01;
    localparam logic [1:0] BR_LTZ = 2'b10;
    localparam logic [1:0] BR_GEZ = 2'b11;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       inv_a;
        logic       inv_b;
        logic       cin;
        logic       sign;
        logic       immed;
        logic       ext_type;
        logic [1:0] len_immed;
        logic       reg_w_en;
        logic [2:0] dst_reg;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic [1:0] br_cond;
        logic       is_br;
        logic       is_jmp;
        logic       jmp_reg;
        logic       link;
        logic       comp;
        logic [1:0] comp_cont;
        logic       pass;
        logic       ex_btr;
        logic       ex_slbi;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;
endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// ctrl_decode_pipe_if: fetch-side and execute-side handshakes plus the registered control bundle
interface ctrl_decode_pipe_if #(parameter int INSTR_W = 16, parameter int REG_W = 3);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         alu_op;
    logic               inv_a;
    logic               inv_b;
    logic               cin;
    logic               sign;
    logic               immed;
    logic               ext_type;
    logic [1:0]         len_immed;
    logic               reg_w_en;
    logic [REG_W-1:0]   dst_reg;
    logic               mem_rd;
    logic               mem_wr;
    logic               mem_to_reg;
    logic [1:0]         br_cond;
    logic               is_br;
    logic               is_jmp;
    logic               jmp_reg;
    logic               link;
    logic               comp;
    logic [1:0]         comp_cont;
    logic               pass;
    logic               ex_btr;
    logic               ex_slbi;
    logic               createdump;
    logic               halted;
    logic               illegal;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, alu_op, inv_a, inv_b, cin, sign, immed, ext_type, len_immed,
               reg_w_en, dst_reg, mem_rd, mem_wr, mem_to_reg, br_cond, is_br, is_jmp, jmp_reg,
               link, comp, comp_cont, pass, ex_btr, ex_slbi, createdump, halted, illegal
    );
    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, alu_op, inv_a, inv_b, cin, sign, immed, ext_type, len_immed,
               reg_w_en, dst_reg, mem_rd, mem_wr, mem_to_reg, br_cond, is_br, is_jmp, jmp_reg,
               link, comp, comp_cont, pass, ex_btr, ex_slbi, createdump, halted, illegal
    );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instr -> control bundle; ILLEGAL_TRAP_EN flags unknown opcodes instead of NOP
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 5
) (
    input  logic [INSTR_W-1:0] i_instr,
    output ctrl_bundle_t       o_ctrl,
    output logic               o_halt,
    output logic               o_illegal
);
    logic [4:0] w_op;
    logic [1:0] w_fn;
    logic [1:0] w_wsel;
    assign w_op = 5'(i_instr[INSTR_W-1 -: OPC_W]);
    assign w_fn = i_instr[1:0];
    always_comb begin
        o_ctrl    = '0;
        o_halt    = 1'b0;
        o_illegal = 1'b0;
        w_wsel    = WSEL_75;
        case (w_op)
            OP_HALT: o_halt = 1'b1;
            OP_NOP: ;
            OP_ADDI, OP_SUBI: begin
                o_ctrl.alu_op   = ALU_ADD;
                o_ctrl.inv_a    = w_op[0];
                o_ctrl.cin      = w_op[0];
                o_ctrl.sign     = 1'b1;
                o_ctrl.immed    = 1'b1;
                o_ctrl.ext_type = 1'b1;
                o_ctrl.reg_w_en = 1'b1;
            end
            OP_XORI, OP_ANDNI: begin
                o_ctrl.alu_op   = w_op[0] ? ALU_ANDN : ALU_XOR;
                o_ctrl.inv_b    = w_op[0];
                o_ctrl.immed    = 1'b1;
                o_ctrl.reg_w_en = 1'b1;
            end
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                o_ctrl.alu_op   = {1'b0, w_op[1:0]};
                o_ctrl.immed    = 1'b1;
                o_ctrl.reg_w_en = 1'b1;
            end
            OP_ST, OP_LD, OP_STU: begin
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.sign       = 1'b1;
                o_ctrl.immed      = 1'b1;
                o_ctrl.ext_type   = 1'b1;
                o_ctrl.mem_rd     = w_op == OP_LD;
                o_ctrl.mem_to_reg = w_op == OP_LD;
                o_ctrl.mem_wr     = w_op != OP_LD;
                o_ctrl.reg_w_en   = w_op != OP_ST;
                w_wsel            = w_op == OP_STU ? WSEL_108 : WSEL_75;
            end
            OP_BTR: begin
                o_ctrl.ex_btr   = 1'b1;
                o_ctrl.reg_w_en = 1'b1;
                w_wsel          = WSEL_42;
            end
            // SUB is Rt - Rs, so the A operand (Rs) is the one inverted
            OP_ALUR: begin
                o_ctrl.alu_op   = w_fn[1] ? (w_fn[0] ? ALU_ANDN : ALU_XOR) : ALU_ADD;
                o_ctrl.inv_a    = w_fn == 2'b01;
                o_ctrl.cin      = w_fn == 2'b01;
                o_ctrl.inv_b    = w_fn == 2'b11;
                o_ctrl.sign     = !w_fn[1];
                o_ctrl.reg_w_en = 1'b1;
                w_wsel          = WSEL_42;
            end
            OP_SHR: begin
                o_ctrl.alu_op   = {1'b0, w_fn};
                o_ctrl.reg_w_en = 1'b1;
                w_wsel          = WSEL_42;
            end
            OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.inv_b     = w_op != OP_SCO;
                o_ctrl.cin       = w_op != OP_SCO;
                o_ctrl.sign      = 1'b1;
                o_ctrl.comp      = 1'b1;
                o_ctrl.comp_cont = w_op[1:0];
                o_ctrl.reg_w_en  = 1'b1;
                w_wsel           = WSEL_42;
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
                o_ctrl.is_br     = 1'b1;
                o_ctrl.br_cond   = w_op[1:0];
                o_ctrl.immed     = 1'b1;
                o_ctrl.ext_type  = 1'b1;
                o_ctrl.len_immed = LEN_8;
            end
            OP_LBI, OP_SLBI: begin
                o_ctrl.pass      = w_op == OP_LBI;
                o_ctrl.ex_slbi   = w_op == OP_SLBI;
                o_ctrl.ext_type  = w_op == OP_LBI;
                o_ctrl.immed     = 1'b1;
                o_ctrl.len_immed = LEN_8;
                o_ctrl.reg_w_en  = 1'b1;
                w_wsel           = WSEL_108;
            end
            OP_J, OP_JR, OP_JAL, OP_JALR: begin
                o_ctrl.is_jmp    = 1'b1;
                o_ctrl.jmp_reg   = w_op[0];
                o_ctrl.link      = w_op[1];
                o_ctrl.reg_w_en  = w_op[1];
                o_ctrl.immed     = 1'b1;
                o_ctrl.ext_type  = 1'b1;
                o_ctrl.len_immed = w_op[0] ? LEN_8 : LEN_11;
                w_wsel           = WSEL_R7;
            end
`ifdef ILLEGAL_TRAP_EN
            default: o_illegal = 1'b1;
`else
            default: ;
`endif
        endcase
        o_ctrl.dst_reg = w_wsel == WSEL_75  ? i_instr[7:5]  :
                         w_wsel == WSEL_42  ? i_instr[4:2]  :
                         w_wsel == WSEL_108 ? i_instr[10:8] : 3'd7;
    end
endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: ID/EX register with handshakes, load-use bubbles and HALT drain; ILLEGAL_TRAP_EN traps unknown ops
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int INSTR_W      = 16,
    parameter int OPC_W        = 5,
    parameter int REG_W        = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input logic clk,
    input logic rst,
    ctrl_decode_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    ctrl_bundle_t     w_dec, r_b;
    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_valid, r_createdump, w_dump_nx;
    logic             w_halt, w_illegal, w_adv, w_lu_stall, w_in_ready, w_accept;

    ctrl_decode #(.INSTR_W(INSTR_W), .OPC_W(OPC_W)) u_dec (
        .i_instr  (bus.instr),
        .o_ctrl   (w_dec),
        .o_halt   (w_halt),
        .o_illegal(w_illegal)
    );

    assign w_adv      = !r_valid || bus.out_ready;
    assign w_lu_stall = r_valid && r_b.mem_rd && r_b.reg_w_en &&
                        (r_b.dst_reg == bus.instr[10:8] || r_b.dst_reg == bus.instr[7:5]);
    assign w_in_ready = r_state == ST_RUN && w_adv && !w_lu_stall && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dump_nx  = 1'b0;
        if (bus.flush && r_state == ST_DRAIN) begin
            w_state_nx = ST_RUN;
            w_cnt_nx   = '0;
        end else if (w_accept && (w_halt || w_illegal)) begin
            w_state_nx = ST_DRAIN;
            w_cnt_nx   = CNT_W'(DRAIN_CYCLES);
        end else if (r_state == ST_DRAIN && w_adv) begin
            w_cnt_nx   = r_cnt - 1'b1;
            w_dump_nx  = r_cnt == CNT_W'(1);
            w_state_nx = r_cnt == CNT_W'(1) ? ST_HALTED : ST_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_valid      <= 1'b0;
            r_b          <= '0;
            r_createdump <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_createdump <= w_dump_nx;
            if (w_accept) begin
                r_valid <= 1'b1;
                r_b     <= w_dec;
            end else if (w_adv || bus.flush) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk) begin
        if (rst) r_illegal <= 1'b0;
        else if (w_accept) r_illegal <= w_illegal;
    end
    assign bus.illegal = r_illegal;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_valid;
    assign bus.alu_op     = r_b.alu_op;
    assign bus.inv_a      = r_b.inv_a;
    assign bus.inv_b      = r_b.inv_b;
    assign bus.cin        = r_b.cin;
    assign bus.sign       = r_b.sign;
    assign bus.immed      = r_b.immed;
    assign bus.ext_type   = r_b.ext_type;
    assign bus.len_immed  = r_b.len_immed;
    assign bus.reg_w_en   = r_b.reg_w_en;
    assign bus.dst_reg    = REG_W'(r_b.dst_reg);
    assign bus.mem_rd     = r_b.mem_rd;
    assign bus.mem_wr     = r_b.mem_wr;
    assign bus.mem_to_reg = r_b.mem_to_reg;
    assign bus.br_cond    = r_b.br_cond;
    assign bus.is_br      = r_b.is_br;
    assign bus.is_jmp     = r_b.is_jmp;
    assign bus.jmp_reg    = r_b.jmp_reg;
    assign bus.link       = r_b.link;
    assign bus.comp       = r_b.comp;
    assign bus.comp_cont  = r_b.comp_cont;
    assign bus.pass       = r_b.pass;
    assign bus.ex_btr     = r_b.ex_btr;
    assign bus.ex_slbi    = r_b.ex_slbi;
    assign bus.createdump = r_createdump;
    assign bus.halted     = r_state == ST_HALTED;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: directed and random checks of ctrl_decode_pipe against a transaction-level model
module tb_ctrl_decode_pipe;
    localparam int DRAIN = 3;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_assert = 0;
    int n_fail = 0;

    ctrl_decode_pipe_if #(.INSTR_W(16), .REG_W(3)) bus ();
    ctrl_decode_pipe #(.INSTR_W(16), .OPC_W(5), .REG_W(3), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    bit          m_v = 1'b0, m_cd = 1'b0, m_ill = 1'b0, m_acc = 1'b0;
    logic [15:0] m_i = 16'h0;
    int          m_st = 0, m_cnt = 0;
    bit          c_r, c_iv, c_fl, c_or;
    logic [15:0] c_ins;
    logic [15:0] rnd;
    int          dumps, dump_at;

    function automatic bit f_wen(input logic [4:0] op);
        return op inside {5'd6, 5'd7, [5'd8:5'd11], [5'd17:5'd31]};
    endfunction

    function automatic logic [2:0] f_dst(input logic [15:0] i);
        logic [4:0] op;
        op = i[15:11];
        if (op inside {5'd6, 5'd7}) return 3'd7;
        if (op inside {5'd18, 5'd19, 5'd24}) return i[10:8];
        if (op inside {[5'd25:5'd31]}) return i[4:2];
        return i[7:5];
    endfunction

    // bit 3 set means the op does not use the ALU in a checkable way
    function automatic logic [3:0] f_alu(input logic [15:0] i);
        logic [4:0] op;
        op = i[15:11];
        if (op inside {5'd8, 5'd9, 5'd16, 5'd17, 5'd19, [5'd28:5'd31]}) return 4'd4;
        if (op == 5'd10) return 4'd6;
        if (op == 5'd11) return 4'd7;
        if (op inside {[5'd20:5'd23]}) return {2'b00, op[1:0]};
        if (op == 5'd26) return {2'b00, i[1:0]};
        if (op == 5'd27) return i[1:0] == 2'd2 ? 4'd6 : i[1:0] == 2'd3 ? 4'd7 : 4'd4;
        return 4'b1000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit iv, input logic [15:0] ins, input bit fl, input bit ordy);
        bit lu, rdy;
        logic [3:0] a;
        @(negedge clk);
        rst = r;
        bus.in_valid = iv;
        bus.instr = ins;
        bus.flush = fl;
        bus.out_ready = ordy;
        #1;
        c_r = r; c_iv = iv; c_ins = ins; c_fl = fl; c_or = ordy;
        lu = m_v && m_i[15:11] == 5'd17 && (f_dst(m_i) == ins[10:8] || f_dst(m_i) == ins[7:5]);
        rdy = m_st == 0 && (!m_v || ordy) && !lu && !fl;
        m_acc = iv && rdy;
        check("in_ready", bus.in_ready, rdy);
        check("out_valid", bus.out_valid, m_v);
        check("createdump", bus.createdump, m_cd);
        check("halted", bus.halted, m_st == 2);
        if (m_v) begin
            a = f_alu(m_i);
            check("reg_w_en", bus.reg_w_en, f_wen(m_i[15:11]));
            check("mem_rd", bus.mem_rd, m_i[15:11] == 5'd17);
            check("mem_wr", bus.mem_wr, m_i[15:11] inside {5'd16, 5'd19});
            check("is_br", bus.is_br, m_i[15:11] inside {[5'd12:5'd15]});
            check("is_jmp", bus.is_jmp, m_i[15:11] inside {[5'd4:5'd7]});
            check("illegal", bus.illegal, m_ill);
            if (f_wen(m_i[15:11])) check("dst_reg", bus.dst_reg, f_dst(m_i));
            if (!a[3]) check("alu_op", bus.alu_op, a[2:0]);
        end
    endtask

    task automatic tick();
        bit adv;
        @(posedge clk);
        if (c_r) begin
            m_v = 0; m_st = 0; m_cnt = 0; m_cd = 0; m_ill = 0;
        end else begin
            adv = !m_v || c_or;
            m_cd = 0;
            if (c_fl) begin
                m_v = 0;
                if (m_st == 1) begin m_st = 0; m_cnt = 0; end
            end else if (m_acc) begin
                m_v = 1;
                m_i = c_ins;
                m_ill = TRAP && c_ins[15:11] inside {5'd2, 5'd3};
                if (c_ins[15:11] == 5'd0 || m_ill) begin m_st = 1; m_cnt = DRAIN; end
            end else begin
                if (m_st == 1 && adv) begin
                    if (m_cnt == 1) begin m_cd = 1; m_st = 2; end
                    m_cnt--;
                end
                if (adv) m_v = 0;
            end
        end
    endtask

    initial begin
        bus.in_valid = 0; bus.instr = '0; bus.flush = 0; bus.out_ready = 1;
        drive(1, 0, 16'h0, 0, 1);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_reg_w_en", bus.reg_w_en, 0);
        check("rst_dst_reg", bus.dst_reg, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_createdump", bus.createdump, 0);
        tick();
        drive(0, 0, 16'h0, 0, 1); tick();

        drive(0, 1, 16'hD94C, 0, 1); tick();
        drive(0, 0, 16'h0, 0, 1);
        check("add_valid", bus.out_valid, 1);
        check("add_alu", bus.alu_op, 3'b100);
        check("add_wen", bus.reg_w_en, 1);
        check("add_dst", bus.dst_reg, 3);
        check("add_cin", bus.cin, 0);
        tick();

        drive(0, 1, 16'h8943, 0, 1);
        check("ld_ready", bus.in_ready, 1);
        tick();
        drive(0, 1, 16'hDA0C, 0, 1);
        check("lu_stall_ready", bus.in_ready, 0);
        check("lu_ld_valid", bus.out_valid, 1);
        tick();
        drive(0, 1, 16'hDA0C, 0, 1);
        check("lu_bubble", bus.out_valid, 0);
        check("lu_ready_again", bus.in_ready, 1);
        tick();
        drive(0, 0, 16'h0, 0, 1);
        check("lu_add_valid", bus.out_valid, 1);
        check("lu_add_dst", bus.dst_reg, 3);
        check("lu_add_memrd", bus.mem_rd, 0);
        tick();

        drive(0, 1, 16'h4A25, 0, 1); tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 16'hD94C, 0, 0);
            check("hold_valid", bus.out_valid, 1);
            check("hold_ready", bus.in_ready, 0);
            check("hold_dst", bus.dst_reg, 1);
            check("hold_alu", bus.alu_op, 3'b100);
            check("hold_inv_a", bus.inv_a, 1);
            check("hold_cin", bus.cin, 1);
            check("hold_immed", bus.immed, 1);
            tick();
        end
        drive(0, 0, 16'h0, 0, 1); tick();

        drive(0, 1, 16'h0000, 0, 1); tick();
        dumps = 0; dump_at = 0;
        for (int k = 1; k <= 7; k++) begin
            drive(0, 1, 16'hD94C, 0, 1);
            check("halt_no_accept", bus.in_ready, 0);
            if (bus.createdump) begin dumps++; dump_at = k; end
            tick();
        end
        check("halt_dump_count", dumps, 1);
        check("halt_dump_cycle", dump_at, DRAIN + 1);
        drive(0, 1, 16'hD94C, 1, 1);
        tick();
        drive(0, 1, 16'hD94C, 0, 1);
        check("halted_flush_ignored", bus.halted, 1);
        check("halted_valid", bus.out_valid, 0);
        tick();
        drive(1, 0, 16'h0, 0, 1); tick();

        drive(0, 1, 16'h0000, 0, 1); tick();
        drive(0, 0, 16'h0, 1, 1); tick();
        drive(0, 1, 16'hD94C, 0, 1);
        check("flush_run_ready", bus.in_ready, 1);
        tick();
        dumps = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 16'h0, 0, 1);
            if (bus.createdump) dumps++;
            tick();
        end
        check("flush_no_dump", dumps, 0);

        drive(0, 1, 16'h0000, 0, 1); tick();
        drive(0, 0, 16'h0, 0, 1); tick();
        drive(1, 0, 16'h0, 0, 1); tick();
        dumps = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 16'h0, 0, 1);
            if (bus.createdump) dumps++;
            tick();
        end
        check("rst_drain_no_dump", dumps, 0);
        check("rst_drain_ready", bus.in_ready, 1);

        drive(0, 1, 16'h1000, 0, 1); tick();
        drive(0, 0, 16'h0, 0, 1);
        check("unk_valid", bus.out_valid, 1);
        check("unk_illegal", bus.illegal, TRAP);
        check("unk_wen", bus.reg_w_en, 0);
        tick();
        dumps = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 16'h0, 0, 1);
            if (bus.createdump) dumps++;
            tick();
        end
        check("unk_dumps", dumps, TRAP ? 1 : 0);
        check("unk_halted", bus.halted, TRAP);
        drive(1, 0, 16'h0, 0, 1); tick();

        for (int k = 0; k < 3000; k++) begin
            rnd = 16'($urandom);
            if ($urandom_range(3) == 0) rnd[15:11] = 5'd17;
            else if (rnd[15:11] inside {5'd0, 5'd2, 5'd3} && $urandom_range(7) != 0) rnd[15:11] = 5'd27;
            drive($urandom_range(199) == 0, $urandom_range(3) != 0, rnd,
                  $urandom_range(15) == 0, $urandom_range(3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
